// File: rtl/sar_guess_pkg.sv
// sar_guess_pkg: shared states, verdict encodings and probe-counter sizing for the SAR guess engine
package sar_guess_pkg;
    typedef enum logic [1:0] {IDLE, GUESS, EVAL, DONE} state_t;
    localparam logic [2:0] V_G = 3'b100;
    localparam logic [2:0] V_E = 3'b010;
    localparam logic [2:0] V_L = 3'b001;
    function automatic int steps_w(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/sar_guess_engine.sv
// sar_guess_engine: binary-search driver that probes an external comparator until it reports equal
module sar_guess_engine
    import sar_guess_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP_W = steps_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_g,
    input  logic              cmp_e,
    input  logic              cmp_l,
    output logic [WIDTH-1:0]  guess,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              err,
    output logic [WIDTH-1:0]  result,
    output logic [STEP_W-1:0] steps
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    state_t state;
    logic [WIDTH-1:0] lo, hi, mid, gm1;
    logic [WIDTH:0] sum, gp1;
    logic [2:0] verdict;
    logic g_ok, l_ok;
    // one extra bit keeps lo+hi and guess+1 exact at the top of the range
    assign sum = {1'b0, lo} + {1'b0, hi};
    assign mid = WIDTH'(sum >> 1);
    assign gp1 = {1'b0, guess} + {1'b0, ONE};
    assign gm1 = guess - ONE;
    assign verdict = {cmp_g, cmp_e, cmp_l};
    assign g_ok = (guess != MAX) && (gp1 <= {1'b0, hi});
    assign l_ok = (guess != '0) && (gm1 >= lo);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            steps  <= '0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    lo     <= '0;
                    hi     <= MAX;
                    found  <= 1'b0;
                    err    <= 1'b0;
                    result <= '0;
                    steps  <= '0;
                    busy   <= 1'b1;
                    state  <= GUESS;
                end
                GUESS: begin
                    guess <= mid;
                    state <= EVAL;
                end
                EVAL: begin
                    steps <= steps + STEP_W'(1);
                    if (verdict == V_G && g_ok) begin
                        lo    <= gp1[WIDTH-1:0];
                        state <= GUESS;
                    end else if (verdict == V_L && l_ok) begin
                        hi    <= gm1;
                        state <= GUESS;
                    end else begin
                        found  <= verdict == V_E;
                        err    <= verdict != V_E;
                        result <= (verdict == V_E) ? guess : '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_guess_engine.sv
// tb_sar_guess_engine: directed scenarios against behavioural secret comparators at WIDTH 2 and 4
module tb_sar_guess_engine;
    import sar_guess_pkg::*;
    logic clk = 0, rst_n = 0, start2 = 0, start4 = 0;
    logic [1:0] secret2 = 0;
    logic [3:0] secret4 = 0;
    int mode4 = 0;
    logic [2:0] v2, v4;
    logic [1:0] guess2, result2, steps2;
    logic busy2, done2, found2, err2;
    logic [3:0] guess4, result4;
    logic [2:0] steps4;
    logic busy4, done4, found4, err4;
    logic [3:0] g_log [8];
    int g_n;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    // mode 1 always answers G, mode 2 answers the contradictory G+E
    always_comb v2 = secret2 > guess2 ? V_G : secret2 == guess2 ? V_E : V_L;
    always_comb v4 = mode4 == 1 ? V_G : mode4 == 2 ? (V_G | V_E) :
                     secret4 > guess4 ? V_G : secret4 == guess4 ? V_E : V_L;

    sar_guess_engine #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .cmp_g(v2[2]), .cmp_e(v2[1]), .cmp_l(v2[0]),
        .guess(guess2), .busy(busy2), .done(done2), .found(found2),
        .err(err2), .result(result2), .steps(steps2)
    );

    sar_guess_engine #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .cmp_g(v4[2]), .cmp_e(v4[1]), .cmp_l(v4[0]),
        .guess(guess4), .busy(busy4), .done(done4), .found(found4),
        .err(err4), .result(result4), .steps(steps4)
    );

    task automatic run4(output int cyc);
        @(negedge clk);
        start4 = 1;
        g_n = 0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start4 = 0;
            if (i % 2 == 0 && g_n < 8) begin g_log[g_n] = guess4; g_n++; end
            if (done4) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks += 9;
        if (guess4 !== 4'd0) begin failures++; $display("FAIL reset_guess got %0d want 0", guess4); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got %0d want 0", busy4); end
        if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done got %0d want 0", done4); end
        if (found4 !== 1'b0) begin failures++; $display("FAIL reset_found got %0d want 0", found4); end
        if (err4 !== 1'b0) begin failures++; $display("FAIL reset_err got %0d want 0", err4); end
        if (result4 !== 4'd0) begin failures++; $display("FAIL reset_result got %0d want 0", result4); end
        if (steps4 !== 3'd0) begin failures++; $display("FAIL reset_steps got %0d want 0", steps4); end
        if (guess2 !== 2'd0) begin failures++; $display("FAIL reset_guess2 got %0d want 0", guess2); end
        if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got %0d want 0", busy2); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_w2();
        logic [1:0] g [3];
        int gi = 0, cyc = 0;
        secret2 = 3;
        @(negedge clk);
        start2 = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start2 = 0;
            if (i % 2 == 0 && gi < 3) begin g[gi] = guess2; gi++; end
            if (done2) begin cyc = i; break; end
        end
        checks += 8;
        if (cyc != 7) begin failures++; $display("FAIL w2_done_cycle got %0d want 7", cyc); end
        if (gi != 3) begin failures++; $display("FAIL w2_probe_count got %0d want 3", gi); end
        else if (g[0] !== 2'd1 || g[1] !== 2'd2 || g[2] !== 2'd3) begin
            failures++; $display("FAIL w2_guesses got %0d,%0d,%0d want 1,2,3", g[0], g[1], g[2]);
        end
        if (found2 !== 1'b1) begin failures++; $display("FAIL w2_found got %0d want 1", found2); end
        if (result2 !== 2'd3) begin failures++; $display("FAIL w2_result got %0d want 3", result2); end
        if (steps2 !== 2'd3) begin failures++; $display("FAIL w2_steps got %0d want 3", steps2); end
        if (err2 !== 1'b0) begin failures++; $display("FAIL w2_err got %0d want 0", err2); end
        @(negedge clk);
        if (done2 !== 1'b0) begin failures++; $display("FAIL w2_done_width got %0d want 0", done2); end
    endtask

    task automatic test_all_secrets();
        int cyc;
        mode4 = 0;
        for (int s = 0; s < 16; s++) begin
            secret4 = 4'(s);
            run4(cyc);
            checks += 5;
            if (cyc == 0) begin failures++; $display("FAIL sweep_timeout secret=%0d got no done want done", s); end
            if (found4 !== 1'b1) begin failures++; $display("FAIL sweep_found secret=%0d got %0d want 1", s, found4); end
            if (result4 !== 4'(s)) begin failures++; $display("FAIL sweep_result got %0d want %0d", result4, s); end
            if (err4 !== 1'b0) begin failures++; $display("FAIL sweep_err secret=%0d got %0d want 0", s, err4); end
            if (steps4 > 3'd5 || steps4 == 3'd0) begin failures++; $display("FAIL sweep_steps secret=%0d got %0d want 1..5", s, steps4); end
            if (s == 7) begin
                checks++;
                if (steps4 !== 3'd1) begin failures++; $display("FAIL sweep_steps7 got %0d want 1", steps4); end
            end
        end
    endtask

    task automatic test_force_g();
        int cyc;
        mode4 = 1;
        run4(cyc);
        mode4 = 0;
        checks += 6;
        if (g_n != 5) begin failures++; $display("FAIL forceg_probe_count got %0d want 5", g_n); end
        else if (g_log[0] !== 4'd7 || g_log[1] !== 4'd11 || g_log[2] !== 4'd13 || g_log[3] !== 4'd14 || g_log[4] !== 4'd15) begin
            failures++;
            $display("FAIL forceg_guesses got %0d,%0d,%0d,%0d,%0d want 7,11,13,14,15", g_log[0], g_log[1], g_log[2], g_log[3], g_log[4]);
        end
        if (err4 !== 1'b1) begin failures++; $display("FAIL forceg_err got %0d want 1", err4); end
        if (found4 !== 1'b0) begin failures++; $display("FAIL forceg_found got %0d want 0", found4); end
        if (steps4 !== 3'd5) begin failures++; $display("FAIL forceg_steps got %0d want 5", steps4); end
        if (cyc != 11) begin failures++; $display("FAIL forceg_done_cycle got %0d want 11", cyc); end
        @(negedge clk);
        checks += 2;
        if (done4 !== 1'b0) begin failures++; $display("FAIL forceg_done_width got %0d want 0", done4); end
        if (err4 !== 1'b1) begin failures++; $display("FAIL forceg_err_hold got %0d want 1", err4); end
    endtask

    task automatic test_ge();
        int cyc;
        mode4 = 2;
        run4(cyc);
        mode4 = 0;
        checks += 5;
        if (cyc != 3) begin failures++; $display("FAIL ge_done_cycle got %0d want 3", cyc); end
        if (err4 !== 1'b1) begin failures++; $display("FAIL ge_err got %0d want 1", err4); end
        if (steps4 !== 3'd1) begin failures++; $display("FAIL ge_steps got %0d want 1", steps4); end
        if (result4 !== 4'd0) begin failures++; $display("FAIL ge_result got %0d want 0", result4); end
        if (found4 !== 1'b0) begin failures++; $display("FAIL ge_found got %0d want 0", found4); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic saw_done = 0;
        secret4 = 0;
        @(negedge clk);
        start4 = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start4 = 0;
        end
        checks += 3;
        if (busy4 !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %0d want 1", busy4); end
        if (guess4 !== 4'd3) begin failures++; $display("FAIL mid_guess_before got %0d want 3", guess4); end
        if (steps4 !== 3'd2) begin failures++; $display("FAIL mid_steps_before got %0d want 2", steps4); end
        rst_n = 0;
        #1;
        checks += 4;
        if (guess4 !== 4'd0) begin failures++; $display("FAIL mid_guess got %0d want 0", guess4); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL mid_busy got %0d want 0", busy4); end
        if (steps4 !== 3'd0) begin failures++; $display("FAIL mid_steps got %0d want 0", steps4); end
        if ({done4, found4, err4, result4} !== 7'd0) begin failures++; $display("FAIL mid_flags got %0h want 0", {done4, found4, err4, result4}); end
        repeat (3) begin
            @(negedge clk);
            if (done4) saw_done = 1;
        end
        rst_n = 1;
        secret4 = 9;
        run4(cyc);
        checks += 4;
        if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_no_done got %0d want 0", saw_done); end
        if (found4 !== 1'b1) begin failures++; $display("FAIL after_rst_found got %0d want 1", found4); end
        if (result4 !== 4'd9) begin failures++; $display("FAIL after_rst_result got %0d want 9", result4); end
        if (steps4 !== 3'd3) begin failures++; $display("FAIL after_rst_steps got %0d want 3", steps4); end
    endtask

    task automatic test_back_to_back();
        int t1 = 0, t2 = 0;
        secret4 = 5;
        mode4 = 0;
        @(negedge clk);
        start4 = 1;
        for (int i = 1; i <= 60 && t2 == 0; i++) begin
            @(negedge clk);
            if (done4) begin
                checks += 3;
                if (steps4 !== 3'd3) begin failures++; $display("FAIL b2b_steps got %0d want 3", steps4); end
                if (result4 !== 4'd5) begin failures++; $display("FAIL b2b_result got %0d want 5", result4); end
                if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_busy_done got %0d want 0", busy4); end
                if (t1 == 0) t1 = i; else t2 = i;
            end
            if (t1 != 0 && i == t1 + 1) begin
                checks++;
                if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_busy_idle got %0d want 0", busy4); end
            end
            if (t1 != 0 && i == t1 + 2) begin
                checks += 2;
                if (busy4 !== 1'b1) begin failures++; $display("FAIL b2b_busy_restart got %0d want 1", busy4); end
                if (steps4 !== 3'd0) begin failures++; $display("FAIL b2b_steps_clear got %0d want 0", steps4); end
            end
        end
        start4 = 0;
        checks += 2;
        if (t1 != 7) begin failures++; $display("FAIL b2b_first_done got %0d want 7", t1); end
        if (t2 - t1 != 8) begin failures++; $display("FAIL b2b_period got %0d want 8", t2 - t1); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_stop got %0d want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_w2();
        test_all_secrets();
        test_force_g();
        test_ge();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sar_guess_engine.md
# sar_guess_engine

Binary-search guess engine: the initiating end of the magnitude-compare interface. It drives a candidate operand `guess` into an external comparator holding a secret value, samples the comparator's G/E/L verdict, and narrows the search range until the secret is found. The engine sits between board switches/buttons and the comparator datapath, and reports the found value and probe count on LEDs.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits; legal range 2 to 16.
- `STEP_W`, default `$clog2(WIDTH+2)`: width of the probe counter.

Ports:
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. Registers are clear while it is low.
- `start` input 1: begins a search when sampled high in IDLE. Ignored in every other state.
- `cmp_g` input 1: secret > guess.
- `cmp_e` input 1: secret == guess.
- `cmp_l` input 1: secret < guess.
- `guess` output WIDTH: registered candidate operand driven to the comparator.
- `busy` output 1: high in GUESS and EVAL.
- `done` output 1: one-cycle pulse when a search ends.
- `found` output 1: last search ended on E; held until the next start.
- `err` output 1: last search ended on an illegal or contradictory verdict; held until the next start.
- `result` output WIDTH: guess value that produced E; 0 if not found; held.
- `steps` output STEP_W: number of EVAL cycles in the last search; held.

## Operation
- Registers: `lo`, `hi` (WIDTH bits each), state, and the outputs above.
- `mid` = (`lo` + `hi`) >> 1, computed at WIDTH+1 bits, so there is no overflow at `hi` = 2^WIDTH−1.
- States:
  - **IDLE**: on `start`, set `lo`=0, `hi`=2^WIDTH−1, and clear `found`, `err`, `result`, `steps`. Go to GUESS.
  - **GUESS**: load `guess`←`mid`. Go to EVAL. This gives the comparator one full cycle to settle.
  - **EVAL**: sample `cmp_*` and increment `steps`. Priority order:
    1. Verdict not exactly one-hot: set `err`, go to DONE.
    2. E: set `found`, `result`←`guess`, go to DONE.
    3. G: if `guess` = 2^WIDTH−1, set `err` and go to DONE. Otherwise set `lo`←`guess`+1 and go to GUESS.
    4. L: if `guess` = 0 or `guess`−1 < `lo`, set `err` and go to DONE. Otherwise set `hi`←`guess`−1 and go to GUESS.
    5. G with `guess`+1 > `hi`: set `err`, go to DONE.
  - **DONE**: assert `done` for this cycle only. Go to IDLE.
- A consistent comparator always terminates within WIDTH+1 EVAL cycles.
- `guess` holds its last value in IDLE and DONE.
- `start` asserted in DONE is ignored; it is accepted the cycle after, in IDLE.

## Timing
- Reset values: state IDLE, `guess`=0, `busy`=0, `done`=0, `found`=0, `err`=0, `result`=0, `steps`=0, `lo`=0, `hi`=0.
- `start` high at edge n:
  - GUESS at n+1; `guess` = first `mid` after edge n+2.
  - First EVAL sample at edge n+3.
- Each probe costs 2 cycles (GUESS + EVAL).
- `done` is high for the cycle after the final EVAL edge. `found`, `err`, `result`, `steps` are valid from that same cycle.
- `busy` is a registered decode of state: it rises one cycle after `start` and falls in DONE.
- Reset asserted mid-search forces IDLE and the reset values immediately. No `done` pulse is produced.
- `cmp_*` are assumed combinational from `guess`; the engine samples them only in EVAL.

## Structure
- Shared package `sar_guess_pkg`: state enum (IDLE, GUESS, EVAL, DONE), verdict encoding constants, and a function `steps_w(width)`.
- Single module; no sub-module required.
- The bench provides a behavioural secret comparator, parameterised by WIDTH, with a fault-injection mode.

## Test plan
- WIDTH=2, secret=3, `start` pulse → guesses 1, 2, 3; `done` at cycle 7 after start; `found`=1, `result`=3, `steps`=3.
- WIDTH=4, every secret 0..15 → `found`=1, `result`=secret, `steps` ≤ 5, `err`=0. Secret 7 is found in 1 step.
- WIDTH=4, comparator forced to G always → probes 7, 11, 13, 14, 15, then `err`=1, `found`=0, `steps`=5.
- Verdict G and E both high at first EVAL → `err`=1, `done` pulse, `steps`=1, `result`=0.
- `rst_n` low during third GUESS → all outputs 0 immediately. A following `start` completes normally.
- `start` held high continuously, secret=5, WIDTH=4 → back-to-back searches: DONE, then IDLE, then restart. `steps` resets each search, and no `start` is accepted while `busy`.
